full_adder_cell: RTL and testbench

//   Full-adder cell: sums two operand bits and a carry-in, producing sum and carry-out.

---
 rtl/full_adder_cell_pkg.sv | 21 ++
 rtl/full_adder_bit.sv | 18 +
 rtl/full_adder_cell.sv | 60 ++++++
 tb/tb_full_adder_cell.sv | 139 +++++++++++++
 4 files changed

// File: rtl/full_adder_cell_pkg.sv
// Shared helpers for the full-adder cell family.
// Bit-level sum and majority carry functions.
package full_adder_cell_pkg;

  function automatic logic fa_sum(
    input logic a,
    input logic b,
    input logic c
  );
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder.
// Chained by full_adder_cell through cin/cout.
module full_adder_bit
  import full_adder_cell_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = fa_sum(a, b, cin);
    cout = fa_carry(a, b, cin);
  end

endmodule

// File: rtl/full_adder_cell.sv
// Ripple-carry full-adder cell with combinational outputs
// and an enabled register stage with async active-high reset.
module full_adder_cell #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic [WIDTH-1:0] s_q_o,
  output logic             c_q_o
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_d;
  logic             cout_q;

  assign carry[0] = c_i;

  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    full_adder_bit u_bit (
      .a    (a_i[k]),
      .b    (b_i[k]),
      .cin  (carry[k]),
      .s    (s_o[k]),
      .cout (carry[k+1])
    );
  end

  assign c_o = carry[WIDTH];

  always_comb begin
    sum_d  = sum_q;
    cout_d = cout_q;
    if (en_i) begin
      sum_d  = s_o;
      cout_d = c_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign s_q_o = sum_q;
  assign c_q_o = cout_q;

endmodule

// File: tb/tb_full_adder_cell.sv
// Directed checks of the 1-bit cell and a 3-bit chain,
// covering combinational, registered and reset behaviour.
module tb_full_adder_cell;

  logic       clk;
  logic       rst;
  logic       en;
  logic       a1, b1, c1;
  logic       s1, co1, sq1, cq1;
  logic [2:0] a3, b3;
  logic       c3;
  logic [2:0] s3, sq3;
  logic       co3, cq3;

  int total;
  int passed;

  full_adder_cell #(.WIDTH(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .a_i   (a1),
    .b_i   (b1),
    .c_i   (c1),
    .en_i  (en),
    .s_o   (s1),
    .c_o   (co1),
    .s_q_o (sq1),
    .c_q_o (cq1)
  );

  full_adder_cell #(.WIDTH(3)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .a_i   (a3),
    .b_i   (b3),
    .c_i   (c3),
    .en_i  (en),
    .s_o   (s3),
    .c_o   (co3),
    .s_q_o (sq3),
    .c_q_o (cq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst = 1'b1;
    en  = 1'b0;
    a1 = 0; b1 = 0; c1 = 0;
    a3 = 0; b3 = 0; c3 = 0;
    #2;
    chk("rst_sq1", {7'd0, sq1}, 8'd0);
    chk("rst_cq1", {7'd0, cq1}, 8'd0);
    chk("rst_sq3", {5'd0, sq3}, 8'd0);
    chk("rst_cq3", {7'd0, cq3}, 8'd0);
    chk("zero_w3", {4'd0, co3, s3}, 8'd0);

    chk("w1_000", {6'd0, co1, s1}, 8'd0);
    b1 = 1; #1;
    chk("w1_010", {6'd0, co1, s1}, 8'd1);

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] e;
      v = 3'(i);
      {a1, b1, c1} = v;
      e = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      #1;
      chk($sformatf("w1_ex%0d", i), {6'd0, co1, s1}, {6'd0, e});
    end

    a3 = 3'b111; b3 = 3'b001; c3 = 0; #1;
    chk("w3_v1", {4'd0, co3, s3}, 8'b0000_1000);
    a3 = 3'b101; b3 = 3'b011; c3 = 1; #1;
    chk("w3_v2", {4'd0, co3, s3}, 8'b0000_1001);
    a3 = 3'b111; b3 = 3'b111; c3 = 1; #1;
    chk("w3_ones", {4'd0, co3, s3}, 8'b0000_1111);

    // Held in reset across an enabled edge: registers stay zero.
    en = 1;
    @(posedge clk); #1;
    chk("rst_hold_cq3", {7'd0, cq3}, 8'd0);
    chk("rst_hold_sq3", {5'd0, sq3}, 8'd0);

    @(negedge clk);
    rst = 0;
    a1 = 1; b1 = 1; c1 = 0;
    a3 = 3'b101; b3 = 3'b011; c3 = 1;
    @(posedge clk); #1;
    chk("reg_sq1", {7'd0, sq1}, 8'd0);
    chk("reg_cq1", {7'd0, cq1}, 8'd1);
    chk("reg_sq3", {5'd0, sq3}, 8'b001);
    chk("reg_cq3", {7'd0, cq3}, 8'd1);

    @(negedge clk);
    en = 0;
    a1 = 0; b1 = 1; c1 = 0;
    a3 = 3'b000; b3 = 3'b010; c3 = 0;
    @(posedge clk); #1;
    chk("hold_sq1", {7'd0, sq1}, 8'd0);
    chk("hold_cq1", {7'd0, cq1}, 8'd1);
    chk("hold_sq3", {5'd0, sq3}, 8'b001);
    chk("hold_comb1", {6'd0, co1, s1}, 8'd1);

    // Asynchronous reset pulse between edges.
    @(negedge clk); #1;
    rst = 1; #1;
    chk("arst_cq1", {7'd0, cq1}, 8'd0);
    chk("arst_sq3", {5'd0, sq3}, 8'd0);
    chk("arst_cq3", {7'd0, cq3}, 8'd0);
    chk("arst_comb1", {6'd0, co1, s1}, 8'd1);
    chk("arst_comb3", {4'd0, co3, s3}, 8'b0000_0010);
    rst = 0;

    @(negedge clk);
    en = 1;
    @(posedge clk); #1;
    chk("post_sq1", {7'd0, sq1}, 8'd1);
    chk("post_cq1", {7'd0, cq1}, 8'd0);
    chk("post_sq3", {5'd0, sq3}, 8'b010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
